// File: rtl/viterbi_pkg.sv
// Shared types and default sizing for the radix-4 Viterbi sequencing controller.
// Defaults describe a 16-symbol frame with a 16-entry survivor memory.
package viterbi_pkg;

   localparam int SYM_W         = 4;
   localparam int DIBIT_W       = 2;
   localparam int VIT_FRAME_LEN = 16;
   localparam int VIT_ADDR_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_BRANCH,
      ST_ACS,
      ST_TRACE,
      ST_DONE
   } vit_ctrl_state_t;

endpackage

// File: rtl/viterbi_ctrl_if.sv
// Controller-facing bundle: symbol intake, BMU/ACS/survivor controls, traceback stream.
// i_abort is present only when VIT_CTRL_ABORT_EN is defined.
interface viterbi_ctrl_if
   import viterbi_pkg::*;
#(
   parameter int ADDR_W = VIT_ADDR_W
) ();

`ifdef VIT_CTRL_ABORT_EN
   logic                i_abort;
`endif
   logic                i_start;
   logic                i_rx_valid;
   logic [SYM_W-1:0]    i_Rx;
   logic                o_rx_ready;
   logic [SYM_W-1:0]    o_Rx;
   logic                o_en_branch;
   logic                o_pm_init;
   logic                o_en_acs;
   logic                o_sv_wr_en;
   logic [ADDR_W-1:0]   o_sv_wr_addr;
   logic                o_en_tb;
   logic [ADDR_W-1:0]   o_tb_addr;
   logic [DIBIT_W-1:0]  i_tb_dibit;
   logic [DIBIT_W-1:0]  o_data;
   logic                o_valid;
   logic                i_ready;
   logic                o_last;
   logic                o_busy;
   logic                o_done;

   modport master (
`ifdef VIT_CTRL_ABORT_EN
      input  i_abort,
`endif
      input  i_start, i_rx_valid, i_Rx, i_tb_dibit, i_ready,
      output o_rx_ready, o_Rx, o_en_branch, o_pm_init, o_en_acs, o_sv_wr_en,
      output o_sv_wr_addr, o_en_tb, o_tb_addr, o_data, o_valid, o_last, o_busy, o_done
   );

   modport slave (
`ifdef VIT_CTRL_ABORT_EN
      output i_abort,
`endif
      output i_start, i_rx_valid, i_Rx, i_tb_dibit, i_ready,
      input  o_rx_ready, o_Rx, o_en_branch, o_pm_init, o_en_acs, o_sv_wr_en,
      input  o_sv_wr_addr, o_en_tb, o_tb_addr, o_data, o_valid, o_last, o_busy, o_done
   );

endinterface

// File: rtl/vit_addr_cnt.sv
// Up/down address counter with synchronous load, enable and terminal-count flag; 1-cycle update.
// Saturates at TERM: an enabled count at the terminal value holds instead of wrapping.
module vit_addr_cnt #(
   parameter int              ADDR_W = 4,
   parameter bit              UP     = 1'b1,
   parameter logic [ADDR_W-1:0] TERM = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              en,
   output logic [ADDR_W-1:0] cnt,
   output logic              tc
);

   assign tc = (cnt == TERM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && !tc) begin
         cnt <= UP ? cnt + 1'b1 : cnt - 1'b1;
      end
   end

endmodule

// File: rtl/viterbi_ctrl.sv
// Viterbi frame sequencer: INIT, then BRANCH/ACS per symbol (2 cycles/symbol), then reverse traceback 1 dibit/cycle;
// waits in BRANCH on !i_rx_valid and holds TRACE outputs on !i_ready. VIT_CTRL_ABORT_EN adds i_abort.
module viterbi_ctrl
   import viterbi_pkg::*;
#(
   parameter int FRAME_LEN = VIT_FRAME_LEN,
   parameter int ADDR_W    = VIT_ADDR_W
) (
   input logic            clk,
   input logic            rst,
   viterbi_ctrl_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

   vit_ctrl_state_t     state, state_nxt;
   logic [ADDR_W-1:0]   sym_cnt, tb_cnt, tb_load_val;
   logic                sym_tc, tb_tc;
   logic                abort, xfer, sym_load, sym_en, tb_load, tb_en;
   logic [SYM_W-1:0]    rx_q;

   logic                rx_ready, en_branch, pm_init, en_acs, sv_wr_en;
   logic                en_tb, valid, last, done;
   logic [ADDR_W-1:0]   sv_wr_addr, tb_addr;
   logic [DIBIT_W-1:0]  data;

`ifdef VIT_CTRL_ABORT_EN
   assign abort = bus.i_abort && (state != ST_IDLE);
`else
   assign abort = 1'b0;
`endif

   assign xfer        = (state == ST_TRACE) && bus.i_ready;
   assign sym_load    = (state == ST_INIT) || abort;
   assign sym_en      = (state == ST_ACS) && !sym_tc;
   assign tb_load     = ((state == ST_ACS) && sym_tc) || abort;
   assign tb_load_val = abort ? '0 : LAST_ADDR;
   assign tb_en       = xfer;

   vit_addr_cnt #(.ADDR_W(ADDR_W), .UP(1'b1), .TERM(LAST_ADDR)) u_sym_cnt (
      .clk(clk), .rst(rst), .load(sym_load), .load_val('0), .en(sym_en),
      .cnt(sym_cnt), .tc(sym_tc)
   );

   vit_addr_cnt #(.ADDR_W(ADDR_W), .UP(1'b0), .TERM('0)) u_tb_cnt (
      .clk(clk), .rst(rst), .load(tb_load), .load_val(tb_load_val), .en(tb_en),
      .cnt(tb_cnt), .tc(tb_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q <= '0;
      end else if (abort) begin
         rx_q <= '0;
      end else if ((state == ST_BRANCH) && bus.i_rx_valid) begin
         rx_q <= bus.i_Rx;
      end
   end

   always_comb begin
      state_nxt  = state;
      rx_ready   = 1'b0;
      en_branch  = 1'b0;
      pm_init    = 1'b0;
      en_acs     = 1'b0;
      sv_wr_en   = 1'b0;
      sv_wr_addr = '0;
      en_tb      = 1'b0;
      tb_addr    = '0;
      valid      = 1'b0;
      data       = '0;
      last       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.i_start) state_nxt = ST_INIT;
         end
         ST_INIT: begin
            pm_init   = 1'b1;
            state_nxt = ST_BRANCH;
         end
         ST_BRANCH: begin
            rx_ready = 1'b1;
            if (bus.i_rx_valid) state_nxt = ST_ACS;
         end
         ST_ACS: begin
            en_branch  = 1'b1;
            en_acs     = 1'b1;
            sv_wr_en   = 1'b1;
            sv_wr_addr = sym_cnt;
            state_nxt  = sym_tc ? ST_TRACE : ST_BRANCH;
         end
         ST_TRACE: begin
            // Outputs follow tb_cnt, which only moves on a transfer, so a stall holds them.
            en_tb   = 1'b1;
            tb_addr = tb_cnt;
            valid   = 1'b1;
            data    = bus.i_tb_dibit;
            last    = tb_tc;
            if (xfer && tb_tc) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   assign bus.o_rx_ready   = rx_ready;
   assign bus.o_Rx         = rx_q;
   assign bus.o_en_branch  = en_branch;
   assign bus.o_pm_init    = pm_init;
   assign bus.o_en_acs     = en_acs;
   assign bus.o_sv_wr_en   = sv_wr_en;
   assign bus.o_sv_wr_addr = sv_wr_addr;
   assign bus.o_en_tb      = en_tb;
   assign bus.o_tb_addr    = tb_addr;
   assign bus.o_data       = data;
   assign bus.o_valid      = valid;
   assign bus.o_last       = last;
   assign bus.o_busy       = (state != ST_IDLE);
   assign bus.o_done       = done;

endmodule

// File: doc/viterbi_ctrl.md
Name: viterbi_ctrl

Overview:
- Sequencing controller for the radix-4 hard-decision Viterbi decoder.
- Accepts a frame of 4-bit received symbols over a valid/ready handshake and drives en_branch into the branch-metric unit.
- Drives the ACS enable and the survivor-memory write address for each symbol.
- After the frame, runs traceback and streams decoded dibits out over a valid/ready handshake.

Parameters:
- FRAME_LEN, 16, symbols per frame; each symbol carries one radix-4 trellis step.
- ADDR_W, 4, survivor-memory address width; must satisfy 2**ADDR_W >= FRAME_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_start  input  1  begin a frame; sampled only in IDLE.
- i_rx_valid  input  1  symbol valid.
- i_Rx  input  4  received symbol.
- o_rx_ready  output  1  controller accepts a symbol this cycle.
- o_Rx  output  4  registered symbol presented to the branch-metric unit.
- o_en_branch  output  1  branch-metric enable.
- o_pm_init  output  1  one-cycle path-metric initialise pulse to the ACS.
- o_en_acs  output  1  ACS update enable.
- o_sv_wr_en  output  1  survivor-memory write enable.
- o_sv_wr_addr  output  ADDR_W  survivor write address.
- o_en_tb  output  1  traceback-unit enable.
- o_tb_addr  output  ADDR_W  survivor read address for traceback.
- i_tb_dibit  input  2  decoded dibit from the traceback unit at o_tb_addr, combinational.
- o_data  output  2  decoded dibit.
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream ready.
- o_last  output  1  final dibit of the frame.
- o_busy  output  1  state != IDLE.
- o_done  output  1  one-cycle frame-complete pulse.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, sym_cnt=0, tb_cnt=0, o_Rx=0.
  - All outputs 0.
  - A reset mid-frame abandons the frame immediately; no o_done is issued.
- FSM states: IDLE, INIT, BRANCH, ACS, TRACE, DONE.
- IDLE: i_start=1 -> INIT. All other inputs ignored.
- INIT (1 cycle):
  - o_pm_init=1, sym_cnt<=0.
  - -> BRANCH.
- BRANCH:
  - o_rx_ready=1.
  - On i_rx_valid=1: o_Rx<=i_Rx, then -> ACS.
  - Otherwise remain in BRANCH; all enables stay 0.
- ACS (1 cycle):
  - o_en_branch=1, o_en_acs=1, o_sv_wr_en=1, o_sv_wr_addr=sym_cnt.
  - If sym_cnt==FRAME_LEN-1: tb_cnt<=FRAME_LEN-1, -> TRACE.
  - Else: sym_cnt<=sym_cnt+1, -> BRANCH.
- Throughput: at best 2 cycles per symbol, i.e. 2*FRAME_LEN cycles for input when i_rx_valid is held high.
- TRACE:
  - o_en_tb=1, o_tb_addr=tb_cnt, o_valid=1, o_data=i_tb_dibit, o_last=(tb_cnt==0).
  - Transfer occurs when o_valid & i_ready.
  - On transfer: if tb_cnt==0 -> DONE, else tb_cnt<=tb_cnt-1.
  - With i_ready=0: o_tb_addr and o_data are held stable and o_valid stays 1.
- Output order: dibits leave in reverse trellis order, from address FRAME_LEN-1 down to 0. Reordering is downstream's job.
- DONE (1 cycle): o_done=1, -> IDLE.
- i_start while busy is ignored; it is not queued.
- Outputs not driven by the current state are 0.
- Counters never wrap; terminal compares are exact.
- Arithmetic: counters are ADDR_W bits, unsigned.

Optional Feature:
- Macro: VIT_CTRL_ABORT_EN.
- When defined:
  - Adds input i_abort (1 bit).
  - i_abort=1 in any state other than IDLE forces -> IDLE on the next edge, clearing counters and outputs. No o_done is issued.
  - i_abort has priority over every other transition.
  - i_abort in IDLE has no effect, including when asserted together with i_start.
- When undefined: the port is absent and a frame always runs to DONE.

Decomposition:
- Package viterbi_pkg holds:
  - state enum vit_ctrl_state_t.
  - SYM_W=4, DIBIT_W=2.
  - Default FRAME_LEN and ADDR_W constants.
- One sub-module, vit_addr_cnt: ADDR_W up/down counter with synchronous load, enable, and terminal-count flag.
  - Instantiated twice: sym_cnt counting up, tb_cnt counting down.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, o_busy=0; i_rx_valid=1 with no start -> o_rx_ready stays 0.
- Start, then 16 back-to-back symbols i_Rx=k[3:0]:
  - o_pm_init pulses once.
  - o_sv_wr_addr steps 0..15 with o_en_branch=o_en_acs=1 every second cycle.
  - o_Rx matches each symbol in its ACS cycle.
- Traceback with i_ready=1 and model i_tb_dibit=addr[1:0] -> o_tb_addr 15..0, o_data 3,2,1,0,..., o_last only at addr 0, o_done one cycle later.
- Backpressure: i_ready=0 for 3 cycles at tb_cnt=9 -> o_tb_addr stays 9 and o_valid stays 1; no dibit lost or duplicated.
- Input gaps: i_rx_valid toggled 1,0,0,1 -> stays in BRANCH during gaps; exactly 16 writes total.
- rst pulsed at sym_cnt=7 -> immediate IDLE, outputs 0, no o_done. With VIT_CTRL_ABORT_EN: i_abort during TRACE -> IDLE next cycle, no o_done.
